// File: rtl/gcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gcd_arbiter
// Purpose  : Round-robin front end sharing one GCD engine among NREQ
//            requesters. It takes one operand pair at a time, pulses the
//            engine start, collects the result (or times out) and returns it
//            on a tagged response channel with backpressure. Pairs with a
//            zero operand skip the engine and return a|b directly.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int BLANK   = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_res,
    output logic                    rsp_err,
    output logic                    eng_start,
    output logic [W-1:0]            eng_a,
    output logic [W-1:0]            eng_b,
    input  logic                    eng_done,
    input  logic [W-1:0]            eng_res,
    output logic                    busy
);

    localparam int c_IDW     = $clog2(NREQ);
    localparam int c_IDW1    = c_IDW + 1;
    // Counter must reach both the blanking window and the timeout limit.
    localparam int c_CNT_MAX = (TIMEOUT > BLANK) ? TIMEOUT : BLANK;
    localparam int c_CNTW    = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX + 1) : 1;
    localparam int c_TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit c_TO_EN   = (TIMEOUT != 0);

    localparam logic [c_CNTW-1:0] c_CNT_SAT = {c_CNTW{1'b1}};
    localparam logic [c_CNTW-1:0] c_CNT_ONE = c_CNTW'(1);
    localparam logic [c_CNTW-1:0] c_BLANK   = c_CNTW'(BLANK);
    localparam logic [c_CNTW-1:0] c_TO_CNT  = c_CNTW'(c_TO_LAST);
    localparam logic [c_IDW1-1:0] c_NREQ    = c_IDW1'(NREQ);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_IDW-1:0]  r_last_grant;
    logic [c_IDW-1:0]  r_id;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_res;
    logic              r_err;
    logic [c_CNTW-1:0] r_cnt;

    logic              w_found;
    logic [c_IDW-1:0]  w_grant;
    logic [c_IDW1-1:0] w_idx;
    logic              w_accept;
    logic [W-1:0]      w_sel_a;
    logic [W-1:0]      w_sel_b;
    logic              w_bypass;
    logic              w_complete;
    logic              w_timeout;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = {1'b0, r_last_grant} + c_IDW1'(i + 1);
            if (w_idx >= c_NREQ) begin
                w_idx = w_idx - c_NREQ;
            end
            if (!w_found && req_valid[w_idx[c_IDW-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[c_IDW-1:0];
            end
        end
    end

    assign w_accept   = (r_state == c_IDLE) && w_found && !reset;
    assign w_sel_a    = req_a[int'(w_grant)*W +: W];
    assign w_sel_b    = req_b[int'(w_grant)*W +: W];
    assign w_bypass   = (w_sel_a == '0) || (w_sel_b == '0);
    // Done is only trusted once the blanking window has elapsed; completion
    // takes priority over a coincident timeout.
    assign w_complete = (r_cnt >= c_BLANK) && eng_done;
    assign w_timeout  = c_TO_EN && (r_cnt == c_TO_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_state_nxt = w_bypass ? c_RESP : c_ISSUE;
                end
            end
            c_ISSUE: w_state_nxt = c_WAIT;
            c_WAIT: begin
                if (w_complete || w_timeout) begin
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State-decoded outputs; the grant is a combinational one-hot.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_accept && (w_grant == c_IDW'(i));
        end
        eng_start = (r_state == c_ISSUE);
        rsp_valid = (r_state == c_RESP);
        busy      = (r_state != c_IDLE);
    end

    // Operand, result, counter and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= c_IDW'(NREQ - 1);
            r_id         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_a  <= w_sel_a;
                        r_b  <= w_sel_b;
                        r_id <= w_grant;
                        if (w_bypass) begin
                            r_res <= w_sel_a | w_sel_b;
                            r_err <= 1'b0;
                        end
                    end
                end
                c_ISSUE: begin
                    r_cnt <= '0;
                end
                c_WAIT: begin
                    if (r_cnt != c_CNT_SAT) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                    if (w_complete) begin
                        r_res <= eng_res;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_res <= '0;
                        r_err <= 1'b1;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_last_grant <= r_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_id  = r_id;
    assign rsp_res = r_res;
    assign rsp_err = r_err;
    assign eng_a   = r_a;
    assign eng_b   = r_b;

endmodule
`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_arbiter
// Purpose  : Self-checking bench for gcd_arbiter with a behavioural GCD
//            engine (normal / stale-done / hung) and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int BLANK   = 2;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_res;
    logic              rsp_err;
    logic              eng_start;
    logic [W-1:0]      eng_a;
    logic [W-1:0]      eng_b;
    logic              eng_done;
    logic [W-1:0]      eng_res;
    logic              busy;

    gcd_arbiter #(.NREQ(NREQ), .W(W), .BLANK(BLANK), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
        .eng_done(eng_done), .eng_res(eng_res), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_start  = 0;
    int   eng_mode = 0;   // 0 normal, 1 stale done held high, 2 hung
    int   eng_lat  = 6;
    logic m_active;
    int   m_since;

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        for (int k = 0; k < 100 && y != 0; k++) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Engine model: cycles since the last start pulse.
    always @(posedge clk) begin
        if (reset) begin
            m_active <= 1'b0;
            m_since  <= 0;
        end else if (eng_start) begin
            m_active <= 1'b1;
            m_since  <= 1;
        end else if (m_since < 1000) begin
            m_since <= m_since + 1;
        end
    end

    // Engine model outputs; stale mode shows a bogus result until cnt reaches 2.
    always_comb begin
        eng_done = 1'b0;
        eng_res  = '0;
        case (eng_mode)
            0: begin
                eng_done = m_active && (m_since >= eng_lat);
                eng_res  = eng_done ? gcd_f(eng_a, eng_b) : '0;
            end
            1: begin
                eng_done = 1'b1;
                eng_res  = (m_active && m_since >= 3) ? gcd_f(eng_a, eng_b) : 32'hDEAD;
            end
            default: ;
        endcase
    end

    // Monitor: one-hot grant, scoreboard push on accept, pop on response.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        logic [W-1:0] a;
        logic [W-1:0] b;
        if (!reset) begin
            if (eng_start) n_start++;
            n_tests++;
            if ($countones(req_ready) > 1) begin
                n_fail++;
                $display("FAIL onehot: req_ready=%b, required at most one bit set", req_ready);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    a = req_a[i*W +: W];
                    b = req_b[i*W +: W];
                    e.id = 2'(i);
                    if (a == 0 || b == 0) begin
                        e.res = a | b;
                        e.err = 1'b0;
                    end else if (eng_mode == 2) begin
                        e.res = '0;
                        e.err = 1'b1;
                    end else begin
                        e.res = gcd_f(a, b);
                        e.err = 1'b0;
                    end
                    exp_q.push_back(e);
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: got id=%0d res=%0d err=%0d, required no response",
                             rsp_id, rsp_res, rsp_err);
                end else begin
                    e   = exp_q.pop_front();
                    got = {rsp_id, rsp_res, rsp_err};
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL rsp: got id=%0d res=%0d err=%0d, required id=%0d res=%0d err=%0d",
                                 rsp_id, rsp_res, rsp_err, e.id, e.res, e.err);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int i;
        for (i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d responses outstanding, required 0", nm, exp_q.size());
        end
    endtask

    task automatic run_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int exp_lat, input int exp_starts, input string nm);
        int  k;
        int  s0;
        bit  got;
        tick();
        req_valid[id]      = 1'b1;
        req_a[id*W +: W]   = a;
        req_b[id*W +: W]   = b;
        rsp_ready          = 1'b1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        s0 = n_start;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_accept: req_ready[%0d] never rose, required within 50 cycles", nm, id);
            tick();
            req_valid[id] = 1'b0;
            return;
        end
        tick();
        req_valid[id] = 1'b0;
        got = 0;
        k   = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            k++;
            if (rsp_valid) got = 1;
        end
        n_tests++;
        if (!got || k != exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: rsp_valid after %0d cycles (seen=%0d), required %0d", nm, k, got, exp_lat);
        end
        n_tests++;
        if (n_start - s0 != exp_starts) begin
            n_fail++;
            $display("FAIL %s_start: %0d eng_start cycles, required %0d", nm, n_start - s0, exp_starts);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        eng_mode = 0; eng_lat = 6;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_tests++;
        if (rsp_valid !== 1'b0 || eng_start !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctl: rsp_valid=%b eng_start=%b, required 0 0", rsp_valid, eng_start);
        end
        n_tests++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
        n_tests++;
        if ({rsp_id, rsp_res, rsp_err} !== '0) begin
            n_fail++; $display("FAIL reset_rsp: id=%0d res=%0d err=%b, required all 0", rsp_id, rsp_res, rsp_err);
        end
        n_tests++;
        if ({eng_a, eng_b} !== '0) begin
            n_fail++; $display("FAIL reset_eng: a=%0d b=%0d, required 0 0", eng_a, eng_b);
        end
    endtask

    task automatic test_single();
        eng_mode = 0; eng_lat = 6;
        run_req(1, 48, 18, 8, 1, "single");
    endtask

    task automatic test_bypass();
        run_req(0, 0, 7, 1, 0, "bypass_0_7");
        run_req(0, 0, 0, 1, 0, "bypass_0_0");
        run_req(3, 9, 0, 1, 0, "bypass_9_0");
    endtask

    task automatic test_fairness();
        int order[6];
        int n;
        reset = 1'b1;
        tick();
        exp_q.delete();
        tick();
        reset = 1'b0; eng_mode = 0; eng_lat = 3; rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = 32'((i + 1) * 6);
            req_b[i*W +: W] = (i == 2) ? 32'd0 : 32'd4;
        end
        req_valid = 4'b1111;
        n = 0;
        for (int c = 0; c < 500 && n < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i] && n < 6) begin
                    order[n] = i;
                    n++;
                end
            end
        end
        tick();
        req_valid = '0;
        n_tests++;
        if (n != 6) begin n_fail++; $display("FAIL fair_count: %0d grants seen, required 6", n); end
        for (int j = 0; j < n; j++) begin
            n_tests++;
            if (order[j] != j % 4) begin
                n_fail++; $display("FAIL fair_order[%0d]: got %0d, required %0d", j, order[j], j % 4);
            end
        end
        drain("fair");
        eng_lat = 6;
    endtask

    task automatic test_backpressure();
        bit got;
        eng_mode = 0; eng_lat = 6;
        tick();
        rsp_ready = 1'b0;
        req_valid[2] = 1'b1; req_a[2*W +: W] = 32'd12; req_b[2*W +: W] = 32'd8;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); if (req_ready[2]) got = 1; end
        tick();
        req_valid[2] = 1'b0;
        req_valid[3] = 1'b1; req_a[3*W +: W] = 32'd0; req_b[3*W +: W] = 32'd3;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); if (rsp_valid) got = 1; end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL bp_rsp: rsp_valid never rose, required within 50 cycles"); end
        for (int j = 0; j < 5; j++) begin
            if (j > 0) begin tick(); @(negedge clk); end
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_res !== 32'd4 || rsp_err !== 1'b0 || req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b id=%0d res=%0d err=%b ready=%b, required 1 2 4 0 0000",
                         j, rsp_valid, rsp_id, rsp_res, rsp_err, req_ready);
            end
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_accept: rsp_valid=%b, required 1", rsp_valid); end
        tick();
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL bp_idle: busy=%b req_ready=%b, required 0 1000", busy, req_ready);
        end
        tick();
        req_valid[3] = 1'b0;
        drain("bp");
    endtask

    task automatic test_stale();
        eng_mode = 1;
        run_req(0, 36, 24, 5, 1, "stale");
        eng_mode = 0;
    endtask

    task automatic test_timeout();
        eng_mode = 2;
        run_req(1, 35, 21, 10, 1, "timeout");
        tick();
        eng_mode = 0;
    endtask

    task automatic test_reset_mid();
        bit got;
        int nv;
        eng_mode = 2; rsp_ready = 1'b1;
        tick();
        req_valid[2] = 1'b1; req_a[2*W +: W] = 32'd10; req_b[2*W +: W] = 32'd4;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); if (req_ready[2]) got = 1; end
        tick();
        req_valid[2] = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || eng_start !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rmid_ctl: busy=%b rsp_valid=%b eng_start=%b ready=%b, required all 0",
                               busy, rsp_valid, eng_start, req_ready);
        end
        n_tests++;
        if ({rsp_id, rsp_res, rsp_err, eng_a, eng_b} !== '0) begin
            n_fail++; $display("FAIL rmid_data: id=%0d res=%0d err=%b a=%0d b=%0d, required all 0",
                               rsp_id, rsp_res, rsp_err, eng_a, eng_b);
        end
        nv = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (rsp_valid) nv++; end
        n_tests++;
        if (nv != 0) begin n_fail++; $display("FAIL rmid_norsp: rsp_valid high %0d cycles, required 0", nv); end
        eng_mode = 0;
        tick();
        req_valid[0] = 1'b1; req_a[0*W +: W] = 32'd0; req_b[0*W +: W] = 32'd5;
        req_valid[1] = 1'b1; req_a[1*W +: W] = 32'd0; req_b[1*W +: W] = 32'd6;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_first: req_ready=%b, required 0001", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); if (req_ready[1]) got = 1; end
        tick();
        req_valid[1] = 1'b0;
        drain("rmid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_bypass();
        test_fairness();
        test_backpressure();
        test_stale();
        test_timeout();
        test_reset_mid();
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin front end that shares a single GCD engine among `NREQ` requesters. It accepts one operand pair at a time over per-requester valid/ready, sequences the engine with a one-cycle start pulse and collects the result. It returns the result on a single tagged response channel with backpressure. Zero operands are short-circuited, and a timeout guards against a hung engine.

## Interface
- `NREQ`, 4: number of requesters, 2..16
- `W`, 32: operand/result width
- `BLANK`, 2: WAIT cycles during which `eng_done` is ignored after start
- `TIMEOUT`, 1023: WAIT-cycle limit before error; 0 disables

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero
- `req_a`  in  NREQ*W  operand a, requester i at bits [i*W +: W]
- `req_b`  in  NREQ*W  operand b, same packing
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accept
- `rsp_id`  out  clog2(NREQ)  index of the served requester
- `rsp_res`  out  W  gcd result
- `rsp_err`  out  1  timeout flag; `rsp_res`=0 when set
- `eng_start`  out  1  one-cycle start pulse to the engine
- `eng_a`, `eng_b`  out  W  operands to the engine, held stable ISSUE through WAIT
- `eng_done`  in  1  engine done, level
- `eng_res`  in  W  engine result
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Arbitrate over `req_valid` round-robin, starting at `last_grant+1` mod NREQ.
  - Assert `req_ready[g]` combinationally for the winner only; the handshake completes in that cycle.
  - Latch `a`, `b` and `id`=g.
  - If a==0 or b==0, bypass the engine: `res`=a|b, `err`=0, go to RESP.
  - Otherwise go to ISSUE.
- **ISSUE**
  - `eng_start`=1 for exactly one cycle.
  - Clear the WAIT counter `cnt`=0, then go to WAIT.
- **WAIT**
  - `cnt` increments each cycle and saturates.
  - Completion: if `cnt`>=BLANK and `eng_done`, latch `res`=`eng_res`, `err`=0, go to RESP.
  - Timeout: else if TIMEOUT!=0 and `cnt`==TIMEOUT-1, set `res`=0, `err`=1, go to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- **RESP**
  - `rsp_valid`=1 with `rsp_id`, `rsp_res` and `rsp_err` stable until `rsp_ready`.
  - On the handshake: `last_grant`=id, go to IDLE.
  - No new request is accepted in that handshake cycle.
- `req_ready` is 0 outside IDLE. A requester may drop `req_valid` before it is granted; it is never served stale data.
- The WAIT counter is wide enough for TIMEOUT, minimum 1 bit.

## Timing
- Reset values: state=IDLE, `last_grant`=NREQ-1 (requester 0 wins first). All outputs are 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_res`, `rsp_err`, `eng_start`, `eng_a`, `eng_b`, `busy`.
- Engine path, accept in cycle T:
  - `eng_start` high in T+1.
  - First WAIT cycle is T+2.
  - Earliest qualifying `eng_done` is T+2+BLANK.
  - `rsp_valid` rises the following cycle, T+5 at BLANK=2.
- Bypass path: accept in T gives `rsp_valid` in T+1.
- Throughput: at most one request per engine job. With zero-cycle response acceptance, the next accept occurs one cycle after the RESP handshake.
- `eng_done` is ignored while `cnt`<BLANK, because the engine's done can be stale from the previous job.
- Reset mid-operation (any state): return to IDLE next cycle with reset values. Any in-flight job is dropped and no response is produced. The engine shares the same reset.
- `rsp_ready` held high while `rsp_valid`=0 has no effect.

## Test plan
- **Single request:** req 1 with (48,18), engine model returns after 6 cycles → `rsp_id`=1, `rsp_res`=6, `rsp_err`=0; `eng_start` is exactly one pulse.
- **Bypass:** req 0 with (0,7) accepted at T → `rsp_valid` at T+1, `rsp_res`=7, `eng_start` never pulses. (0,0) → `rsp_res`=0.
- **Fairness:** all 4 requesters hold valid continuously after reset → service order 0,1,2,3,0,1. Only one `req_ready` bit is ever high.
- **Backpressure:** `rsp_ready` low for 5 cycles in RESP → `rsp_valid`/`rsp_id`/`rsp_res` stable, `req_ready`=0 throughout. Accept on cycle 6, then IDLE.
- **Stale done and timeout:**
  - `eng_done` held high through ISSUE and the first 2 WAIT cycles → ignored; first qualifying cycle at `cnt`=2.
  - With TIMEOUT=8 and `eng_done` tied 0 → `rsp_err`=1, `rsp_res`=0 after 8 WAIT cycles.
- **Reset mid-WAIT:** assert reset for one cycle → next cycle IDLE, `busy`=0, all outputs 0; no response issued. A new request from requester 0 is granted first.
